pll_lock_supervisor: RTL

//  Sequences an iCE40 SB_PLL40_CORE from power-up to a usable output clock. Runs in the
//  PLL reference-clock domain: pulses PLL RESETB, synchronises and qualifies LOCK, and

---
 rtl/pll_lock_supervisor.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/pll_lock_supervisor.sv
// Power-up sequencer for an iCE40 SB_PLL40_CORE: pulses RESETB, qualifies a synchronised LOCK,
// releases the downstream reset once lock is stable, recovers from lock loss and latches a fault.
module pll_lock_supervisor #(
  parameter int RESET_HOLD  = 16,
  parameter int LOCK_TMO    = 4096,
  parameter int LOCK_STABLE = 256,
  parameter int MAX_RETRIES = 3,
  parameter int CNT_W       = 16
) (
  input  logic       clock_in,
  input  logic       resetn,
  input  logic       pll_locked,
  input  logic       restart_req,
  output logic       pll_resetb,
  output logic       sys_resetn,
  output logic       pll_ready,
  output logic       fault,
  output logic [1:0] retry_cnt,
  output logic [7:0] loss_cnt,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_RESET_PLL = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RUN       = 3'd3,
    S_FAULT     = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RESET_HOLD - 1);
  localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(LOCK_TMO - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE - 1);
  localparam logic [1:0]       RETRY_LAST  = 2'(MAX_RETRIES);

  state_t           cur, nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [1:0]       retry_nxt;
  logic [7:0]       loss_nxt;
  logic             sync1, lk;

  assign state = cur;

  // LOCK is asynchronous to clock_in; lk is the second synchroniser stage.
  always_ff @(posedge clock_in) begin
    if (!resetn) begin
      sync1 <= 1'b0;
      lk    <= 1'b0;
    end else begin
      sync1 <= pll_locked;
      lk    <= sync1;
    end
  end

  // restart_req is a one-cycle request with no acknowledge: whenever it is high at an edge
  // the sequence restarts from RESET_PLL, overriding every other transition that cycle.
  always_comb begin
    nxt       = cur;
    cnt_nxt   = cnt;
    retry_nxt = retry_cnt;
    loss_nxt  = loss_cnt;
    if (restart_req) begin
      nxt       = S_RESET_PLL;
      cnt_nxt   = '0;
      retry_nxt = 2'd0;
    end else begin
      case (cur)
        S_RESET_PLL: begin
          if (cnt == HOLD_LAST) begin
            nxt     = S_WAIT_LOCK;
            cnt_nxt = '0;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        S_WAIT_LOCK: begin
          if (lk) begin
            nxt     = S_STABLE;
            cnt_nxt = '0;
          end else if (cnt == TMO_LAST) begin
            cnt_nxt = '0;
            if (retry_cnt == RETRY_LAST) begin
              nxt = S_FAULT;
            end else begin
              nxt       = S_RESET_PLL;
              retry_nxt = (retry_cnt == 2'd3) ? retry_cnt : retry_cnt + 2'd1;
            end
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        S_STABLE: begin
          if (!lk) begin
            nxt     = S_WAIT_LOCK;
            cnt_nxt = '0;
          end else if (cnt == STABLE_LAST) begin
            nxt       = S_RUN;
            cnt_nxt   = '0;
            retry_nxt = 2'd0;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        S_RUN: begin
          if (!lk) begin
            nxt      = S_RESET_PLL;
            cnt_nxt  = '0;
            loss_nxt = (loss_cnt == 8'hFF) ? loss_cnt : loss_cnt + 8'd1;
          end
        end
        S_FAULT: begin
          cnt_nxt = '0;
        end
        default: begin
          nxt     = S_RESET_PLL;
          cnt_nxt = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_ff @(posedge clock_in) begin
    if (!resetn) begin
      cur        <= S_RESET_PLL;
      cnt        <= '0;
      retry_cnt  <= 2'd0;
      loss_cnt   <= 8'd0;
      pll_resetb <= 1'b0;
      sys_resetn <= 1'b0;
      pll_ready  <= 1'b0;
      fault      <= 1'b0;
    end else begin
      cur        <= nxt;
      cnt        <= cnt_nxt;
      retry_cnt  <= retry_nxt;
      loss_cnt   <= loss_nxt;
      pll_resetb <= (nxt == S_WAIT_LOCK) || (nxt == S_STABLE) || (nxt == S_RUN);
      sys_resetn <= (nxt == S_RUN);
      pll_ready  <= (nxt == S_RUN);
      fault      <= (nxt == S_FAULT);
    end
  end

endmodule
